// File: rtl/jtframe_dwnld.sv
// ROM download router: splits ioctl bytes between a PROM write port and a
// buffered SDRAM write port with a simple IDLE/WR/GAP handshake FSM.
module jtframe_dwnld #(
    parameter logic [21:0] PROM_START = 22'h200000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        downloading,
    input  logic [21:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    output logic [21:0] prog_addr,
    output logic [7:0]  prog_data,
    output logic [1:0]  prog_mask,
    output logic        prog_we,
    input  logic        prog_ack,
    output logic [21:0] prom_addr,
    output logic [7:0]  prom_data,
    output logic        prom_we,
    output logic        dwnld_busy,
    output logic        overrun
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW-1:0] PTR_ZERO = PW'(0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic [29:0]   mem_r [FIFO_DEPTH];
    logic [29:0]   head_s;
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_idx_s;
    logic [PW-1:0] wr_ptr_next_s;
    logic [PW-1:0] rd_ptr_next_s;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    logic          dl_prev_r;
    logic          flush_s;
    logic          valid_wr_s;
    logic          is_prom_s;
    logic          sdram_wr_s;
    logic          full_s;
    logic          empty_s;
    logic          push_s;
    logic          drop_s;
    logic          pop_s;

    // Classify the incoming byte and decide push/drop/pop for this cycle.
    // A flush (download start) empties the FIFO first, so a byte arriving
    // on that same cycle always finds room and lands in slot zero.
    always_comb begin
        valid_wr_s = ioctl_wr & downloading;
        is_prom_s  = (ioctl_addr >= PROM_START);
        flush_s    = downloading & ~dl_prev_r;
        sdram_wr_s = valid_wr_s & ~is_prom_s;
        full_s     = (count_r == DEPTH_C);
        empty_s    = (count_r == CNT_ZERO);
        push_s     = sdram_wr_s & (flush_s | ~full_s);
        drop_s     = sdram_wr_s & ~flush_s & full_s;
        pop_s      = (state_r == ST_IDLE) & ~empty_s & ~flush_s;
        head_s     = mem_r[rd_ptr_r];
    end

    // Next pointer and occupancy values, including the flush case.
    always_comb begin
        wr_idx_s      = flush_s ? PTR_ZERO : wr_ptr_r;
        wr_ptr_next_s = push_s ? (wr_idx_s + PTR_ONE) : wr_idx_s;
        if (flush_s) begin
            rd_ptr_next_s = PTR_ZERO;
            count_next_s  = push_s ? CNT_ONE : CNT_ZERO;
        end else begin
            rd_ptr_next_s = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
            case ({push_s, pop_s})
                2'b10:   count_next_s = count_r + CNT_ONE;
                2'b01:   count_next_s = count_r - CNT_ONE;
                default: count_next_s = count_r;
            endcase
        end
    end

    // Next state of the SDRAM write FSM.
    always_comb begin
        case (state_r)
            ST_IDLE: state_next_s = pop_s ? ST_WR : ST_IDLE;
            ST_WR:   state_next_s = prog_ack ? ST_GAP : ST_WR;
            ST_GAP:  state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FIFO storage; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_idx_s] <= {ioctl_addr, ioctl_data};
        end
    end

    // FIFO pointers, occupancy, edge detector and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            dl_prev_r  <= 1'b0;
            dwnld_busy <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            wr_ptr_r   <= wr_ptr_next_s;
            rd_ptr_r   <= rd_ptr_next_s;
            count_r    <= count_next_s;
            dl_prev_r  <= downloading;
            dwnld_busy <= downloading | (count_next_s != CNT_ZERO) | (state_next_s != ST_IDLE);
            if (flush_s) begin
                overrun <= 1'b0;
            end else if (drop_s) begin
                overrun <= 1'b1;
            end else begin
                overrun <= overrun;
            end
        end
    end

    // SDRAM write FSM: present the FIFO head and hold it until acknowledged.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            prog_addr <= 22'h000000;
            prog_data <= 8'h00;
            prog_mask <= 2'b11;
            prog_we   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        prog_addr <= {1'b0, head_s[29:9]};
                        prog_data <= head_s[7:0];
                        prog_mask <= head_s[8] ? 2'b01 : 2'b10;
                        prog_we   <= 1'b1;
                    end else begin
                        prog_we <= 1'b0;
                    end
                end
                ST_WR: begin
                    if (prog_ack) begin
                        prog_we <= 1'b0;
                    end else begin
                        prog_we <= 1'b1;
                    end
                end
                ST_GAP:  prog_we <= 1'b0;
                default: prog_we <= 1'b0;
            endcase
        end
    end

    // PROM bypass: one-cycle strobe with address/data held until the next byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            prom_addr <= 22'h000000;
            prom_data <= 8'h00;
            prom_we   <= 1'b0;
        end else if (valid_wr_s && is_prom_s) begin
            prom_addr <= ioctl_addr - PROM_START;
            prom_data <= ioctl_data;
            prom_we   <= 1'b1;
        end else begin
            prom_we <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jtframe_dwnld.sv
module tb_jtframe_dwnld;

    logic        clk;
    logic        rst;
    logic        downloading;
    logic [21:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we;
    logic        prog_ack;
    logic [21:0] prom_addr;
    logic [7:0]  prom_data;
    logic        prom_we;
    logic        dwnld_busy;
    logic        overrun;

    jtframe_dwnld #(.PROM_START(22'h200000), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
        .prog_we(prog_we), .prog_ack(prog_ack),
        .prom_addr(prom_addr), .prom_data(prom_data), .prom_we(prom_we),
        .dwnld_busy(dwnld_busy), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [21:0] pa;
        logic [1:0]  pm;
        logic [7:0]  pd;
        logic        rwe;
        logic [21:0] ra;
        logic [7:0]  rd;
        logic        busy;
        logic        ovr;
    } outs_t;

    typedef struct packed {
        logic        dl;
        logic        wr;
        logic [21:0] a;
        logic [7:0]  d;
        logic        ack;
        outs_t       e;
    } vec_t;

    int total = 0;
    int bad = 0;
    logic [31:0] got_q[$];
    vec_t tbl[15];

    function automatic outs_t o(input logic we, input logic [21:0] pa, input logic [1:0] pm,
                                input logic [7:0] pd, input logic rwe, input logic [21:0] ra,
                                input logic [7:0] rd, input logic busy, input logic ovr);
        outs_t r;
        r = '{we, pa, pm, pd, rwe, ra, rd, busy, ovr};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; downloading = 1'b0; ioctl_wr = 1'b0;
        ioctl_addr = 22'h0; ioctl_data = 8'h0; prog_ack = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [21:0] a, input logic [7:0] d);
        ioctl_wr = 1'b1; ioctl_addr = a; ioctl_data = d;
        tick();
        ioctl_wr = 1'b0;
    endtask

    // Acknowledge every write request once, recording {mask, addr, data}.
    task automatic drain(input int cycles);
        got_q.delete();
        for (int i = 0; i < cycles; i++) begin
            if (prog_we && !prog_ack) begin
                got_q.push_back({prog_mask, prog_addr, prog_data});
                prog_ack = 1'b1;
            end else begin
                prog_ack = 1'b0;
            end
            tick();
        end
        prog_ack = 1'b0;
    endtask

    logic [31:0] exp_a[5];
    logic [31:0] exp_b[4];

    initial begin
        outs_t cur;
        outs_t w2;
        outs_t w2p;
        outs_t idle;

        idle = o(1'b0, 22'h0, 2'b11, 8'h00, 1'b0, 22'h0, 8'h00, 1'b0, 1'b0);
        w2   = o(1'b1, 22'h2, 2'b01, 8'hA5, 1'b0, 22'h0, 8'h00, 1'b1, 1'b0);
        w2p  = o(1'b0, 22'h2, 2'b01, 8'hA5, 1'b0, 22'h10, 8'h3C, 1'b0, 1'b0);
        tbl[0]  = '{1'b0, 1'b0, 22'h0, 8'h00, 1'b0, idle};
        tbl[1]  = '{1'b1, 1'b0, 22'h0, 8'h00, 1'b0, idle};
        tbl[2]  = '{1'b1, 1'b1, 22'h5, 8'hA5, 1'b0, idle};
        tbl[3]  = '{1'b1, 1'b0, 22'h0, 8'h00, 1'b0,
                    o(1'b0, 22'h0, 2'b11, 8'h00, 1'b0, 22'h0, 8'h00, 1'b1, 1'b0)};
        tbl[2].e.busy = 1'b1;
        tbl[4]  = '{1'b1, 1'b0, 22'h0, 8'h00, 1'b0, w2};
        tbl[5]  = '{1'b1, 1'b0, 22'h0, 8'h00, 1'b0, w2};
        tbl[6]  = '{1'b1, 1'b0, 22'h0, 8'h00, 1'b0, w2};
        tbl[7]  = '{1'b1, 1'b0, 22'h0, 8'h00, 1'b1, w2};
        tbl[8]  = '{1'b1, 1'b1, 22'h200010, 8'h3C, 1'b0,
                    o(1'b0, 22'h2, 2'b01, 8'hA5, 1'b0, 22'h0, 8'h00, 1'b1, 1'b0)};
        tbl[9]  = '{1'b0, 1'b0, 22'h0, 8'h00, 1'b0,
                    o(1'b0, 22'h2, 2'b01, 8'hA5, 1'b1, 22'h10, 8'h3C, 1'b1, 1'b0)};
        tbl[10] = '{1'b0, 1'b0, 22'h0, 8'h00, 1'b0, w2p};
        tbl[11] = '{1'b0, 1'b1, 22'h7, 8'h11, 1'b0, w2p};
        tbl[12] = '{1'b0, 1'b1, 22'h200003, 8'h22, 1'b0, w2p};
        tbl[13] = '{1'b0, 1'b0, 22'h0, 8'h00, 1'b0, w2p};
        tbl[14] = '{1'b0, 1'b0, 22'h0, 8'h00, 1'b0, w2p};

        exp_a[0] = {2'b10, 22'h0, 8'h10};
        exp_a[1] = {2'b01, 22'h0, 8'h11};
        exp_a[2] = {2'b10, 22'h1, 8'h12};
        exp_a[3] = {2'b01, 22'h1, 8'h13};
        exp_a[4] = {2'b10, 22'h2, 8'h14};
        exp_b[0] = {2'b01, 22'h100, 8'h51};
        exp_b[1] = {2'b10, 22'h101, 8'h52};
        exp_b[2] = {2'b01, 22'h101, 8'h53};
        exp_b[3] = {2'b10, 22'h102, 8'h54};

        // Table: reset state, single SDRAM byte, PROM byte, ignored bytes.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            downloading = tbl[i].dl;
            ioctl_wr    = tbl[i].wr;
            ioctl_addr  = tbl[i].a;
            ioctl_data  = tbl[i].d;
            prog_ack    = tbl[i].ack;
            cur = '{prog_we, prog_addr, prog_mask, prog_data, prom_we, prom_addr,
                    prom_data, dwnld_busy, overrun};
            chk($sformatf("row%0d", i), 128'(cur), 128'(tbl[i].e));
            tick();
        end
        ioctl_wr = 1'b0; prog_ack = 1'b0;

        // Overrun: one in WR, four buffered, sixth dropped.
        do_reset();
        downloading = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            push(22'(k), 8'h10 + 8'(k));
        end
        chk("ovr_set", 128'(overrun), 128'(1'b1));
        chk("ovr_wr_head", 128'({prog_we, prog_mask, prog_addr, prog_data}),
            128'({1'b1, 2'b10, 22'h0, 8'h10}));
        drain(100);
        chk("ovr_count", 128'(got_q.size()), 128'(5));
        for (int k = 0; k < 5; k++) begin
            if (k < got_q.size()) begin
                chk($sformatf("ovr_wr%0d", k), 128'(got_q[k]), 128'(exp_a[k]));
            end else begin
                chk($sformatf("ovr_wr%0d", k), 128'(32'hFFFFFFFF), 128'(exp_a[k]));
            end
        end

        // Flush on download restart: in-flight write survives, buffer is dropped.
        push(22'h100, 8'h40);
        push(22'h101, 8'h41);
        push(22'h102, 8'h42);
        downloading = 1'b0;
        tick();
        downloading = 1'b1;
        chk("sticky_ovr", 128'(overrun), 128'(1'b1));
        tick();
        chk("restart_clr_ovr", 128'(overrun), 128'(1'b0));
        chk("flush_keeps_wr", 128'(prog_we), 128'(1'b1));
        drain(50);
        chk("flush_count", 128'(got_q.size()), 128'(1));
        if (got_q.size() > 0) begin
            chk("flush_wr0", 128'(got_q[0]), 128'({2'b10, 22'h80, 8'h40}));
        end

        // Push and pop in the same cycle with the FIFO full.
        for (int k = 0; k < 5; k++) begin
            push(22'h200 + 22'(k), 8'h50 + 8'(k));
        end
        chk("full_no_ovr", 128'(overrun), 128'(1'b0));
        chk("full_we", 128'(prog_we), 128'(1'b1));
        prog_ack = 1'b1;
        tick();
        prog_ack = 1'b0;
        chk("gap_we_low", 128'(prog_we), 128'(1'b0));
        tick();
        push(22'h2FF, 8'hEE);
        chk("pp_ovr", 128'(overrun), 128'(1'b1));
        chk("pp_pop", 128'({prog_we, prog_mask, prog_addr, prog_data}),
            128'({1'b1, exp_b[0]}));
        drain(100);
        chk("pp_count", 128'(got_q.size()), 128'(4));
        for (int k = 0; k < 4; k++) begin
            if (k < got_q.size()) begin
                chk($sformatf("pp_wr%0d", k), 128'(got_q[k]), 128'(exp_b[k]));
            end
        end

        // Reset in the middle of a write with two bytes buffered.
        do_reset();
        downloading = 1'b1;
        tick();
        push(22'h300, 8'h60);
        push(22'h301, 8'h61);
        push(22'h302, 8'h62);
        downloading = 1'b0;
        tick();
        chk("pre_rst_we", 128'(prog_we), 128'(1'b1));
        rst = 1'b1;
        tick();
        chk("rst_out", 128'({prog_we, dwnld_busy, prog_mask}), 128'({1'b0, 1'b0, 2'b11}));
        rst = 1'b0;
        drain(30);
        chk("rst_no_writes", 128'(got_q.size()), 128'(0));
        chk("rst_idle_busy", 128'(dwnld_busy), 128'(1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
